// File: rtl/cfg_arb_pkg.sv
// ============================================================================
// Module   : cfg_arb_pkg
// Brief    : Shared types and constants for the config source arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SESSION = 2'd1,
    FLUSH   = 2'd2
  } arb_state_e;

  localparam logic OWNER_UART = 1'b0;
  localparam logic OWNER_USB  = 1'b1;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BYTES_PER_WORD - 1);

  // Slot 0 is the most significant byte of the config word.
  function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [CNT_W-1:0] slot);
    place_byte = {b, 24'h000000} >> (8 * slot);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_word_packer.sv
// ============================================================================
// Module   : cfg_word_packer
// Brief    : Packs accepted bytes into 32-bit words and holds the output word
//            until the consumer handshakes it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_word_packer
  import cfg_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             byte_last,
  input  logic             flush,
  input  logic             word_ready,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             word_valid,
  output logic [31:0]      word_data,
  output logic             word_last
);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pack;
  logic             r_word_valid;
  logic [31:0]      r_word_data;
  logic             r_word_last;
  logic [31:0]      w_packed;
  logic             w_full;

  assign w_packed = r_pack | place_byte(byte_data, r_cnt);
  assign w_full   = (r_cnt == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_pack       <= '0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_word_last  <= 1'b0;
    end else begin
      if (r_word_valid && word_ready) begin
        r_word_valid <= 1'b0;
        r_word_data  <= '0;
        r_word_last  <= 1'b0;
      end
      // A last byte ends the word early; unfilled low slots stay zero.
      if (byte_valid) begin
        if (w_full || byte_last) begin
          r_word_valid <= 1'b1;
          r_word_data  <= w_packed;
          r_word_last  <= byte_last;
          r_cnt        <= '0;
          r_pack       <= '0;
        end else begin
          r_pack <= w_packed;
          r_cnt  <= r_cnt + 1'b1;
        end
      end else if (flush) begin
        r_word_valid <= 1'b1;
        r_word_data  <= r_pack;
        r_word_last  <= 1'b1;
        r_cnt        <= '0;
        r_pack       <= '0;
      end
    end
  end

  assign byte_cnt   = r_cnt;
  assign word_valid = r_word_valid;
  assign word_data  = r_word_data;
  assign word_last  = r_word_last;

endmodule

`default_nettype wire

// File: rtl/config_source_arbiter.sv
// ============================================================================
// Module   : config_source_arbiter
// Brief    : Grants UART or USB DFU a whole bitstream session and packs its
//            bytes into config words. Idle timeout enabled by CFG_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_source_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int PRIO_USB       = 1,
  parameter int TIMEOUT_CYCLES = 1250000,
  parameter int TIMEOUT_W      = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_valid_i,
  input  logic [7:0]  uart_data_i,
  input  logic        uart_last_i,
  output logic        uart_ready_o,
  input  logic        usb_valid_i,
  input  logic [7:0]  usb_data_i,
  input  logic        usb_last_i,
  output logic        usb_ready_o,
  output logic        word_valid_o,
  output logic [31:0] word_data_o,
  output logic        word_last_o,
  input  logic        word_ready_i,
  output logic        active_o,
  output logic        owner_o,
  output logic        timeout_o
);

  arb_state_e       r_state;
  arb_state_e       w_next;
  logic             r_owner;
  logic             w_owner_valid;
  logic [7:0]       w_owner_data;
  logic             w_owner_last;
  logic             w_byte_ready;
  logic             w_accept;
  logic             w_word_hs;
  logic             w_grant_usb;
  logic             w_timeout_fire;
  logic             w_flush;
  logic [CNT_W-1:0] w_byte_cnt;

  assign w_owner_valid = (r_owner == OWNER_USB) ? usb_valid_i : uart_valid_i;
  assign w_owner_data  = (r_owner == OWNER_USB) ? usb_data_i  : uart_data_i;
  assign w_owner_last  = (r_owner == OWNER_USB) ? usb_last_i  : uart_last_i;

  assign w_byte_ready = (r_state == SESSION) && !word_valid_o;
  assign w_accept     = w_byte_ready && w_owner_valid;
  assign w_word_hs    = word_valid_o && word_ready_i;
  assign w_grant_usb  = usb_valid_i && (!uart_valid_i || (PRIO_USB != 0));
  assign w_flush      = w_timeout_fire && (w_byte_cnt != '0);

  assign uart_ready_o = w_byte_ready && (r_owner == OWNER_UART);
  assign usb_ready_o  = w_byte_ready && (r_owner == OWNER_USB);
  assign active_o     = (r_state != IDLE);
  assign owner_o      = r_owner;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (uart_valid_i || usb_valid_i) w_next = SESSION;
      end
      SESSION: begin
        if (w_accept && w_owner_last && (w_byte_cnt != LAST_SLOT)) begin
          w_next = FLUSH;
        end else if (w_word_hs && word_last_o) begin
          w_next = IDLE;
        end else if (w_timeout_fire) begin
          w_next = (w_byte_cnt != '0) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (w_word_hs) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= OWNER_UART;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && (uart_valid_i || usb_valid_i)) begin
        r_owner <= w_grant_usb ? OWNER_USB : OWNER_UART;
      end
    end
  end

`ifdef CFG_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] c_tmo_max = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] r_tmo_cnt;
  logic                 r_timeout;

  // Waiting on the consumer is not source idleness, so the count holds then.
  assign w_timeout_fire = (r_state == SESSION) && !word_valid_o && !w_accept &&
                          (r_tmo_cnt == c_tmo_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_fire;
      if ((r_state != SESSION) || w_accept || w_timeout_fire) begin
        r_tmo_cnt <= '0;
      end else if (!word_valid_o) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_timeout_fire = 1'b0;
  // Timeout parameters are kept referenced so both builds share one interface.
  assign timeout_o = 1'b0 & (TIMEOUT_CYCLES > TIMEOUT_W);
`endif

  cfg_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (w_accept),
    .byte_data  (w_owner_data),
    .byte_last  (w_owner_last),
    .flush      (w_flush),
    .word_ready (word_ready_i),
    .byte_cnt   (w_byte_cnt),
    .word_valid (word_valid_o),
    .word_data  (word_data_o),
    .word_last  (word_last_o)
  );

endmodule

`default_nettype wire
